// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage : pipeline_pkg

// File: rtl/forward_sel.sv
// Operand forwarding select for one execute-stage ALU source.
module forward_sel
  import pipeline_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] em_rd,
  input  logic       em_reg_write,
  input  logic       em_mem_read,
  input  logic [4:0] mw_rd,
  input  logic       mw_reg_write,
  output logic [1:0] sel
);

  // Memory-stage ALU result wins over writeback; loads in memory have no data yet, x0 never forwards.
  always_comb begin
    sel = FWD_REG;
    if (em_reg_write && !em_mem_read && (em_rd != REG_X0) && (em_rd == rs)) begin
      sel = FWD_MEM;
    end else if (mw_reg_write && (mw_rd != REG_X0) && (mw_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule : forward_sel

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller: stalls, flushes, forwarding and memory-wait freeze.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [4:0]       d_rs1_i,
  input  logic [4:0]       d_rs2_i,
  input  logic             d_use_rs1_i,
  input  logic             d_use_rs2_i,
  input  logic [4:0]       de_rs1_i,
  input  logic [4:0]       de_rs2_i,
  input  logic [4:0]       de_rd_i,
  input  logic             de_reg_write_i,
  input  logic             de_mem_read_i,
  input  logic             e_pc_select_i,
  input  logic [4:0]       em_write_addr_reg_i,
  input  logic             em_reg_write_i,
  input  logic             em_mem_read_i,
  input  logic             em_mem_write_i,
  input  logic             dmem_ready_i,
  input  logic [4:0]       mw_write_addr_reg_i,
  input  logic             mw_reg_write_i,
  output logic             pc_write_o,
  output logic             fd_write_o,
  output logic             fd_flush_o,
  output logic             de_flush_o,
  output logic             pipe_freeze_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_t            state;
  state_t            state_nxt;
  logic              mem_busy;
  logic              load_use;
  logic              stall_inc;
  logic              flush_inc;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  // Execute-stage write enable is not needed: load_use keys on mem_read alone.
  logic unused_inputs;
  assign unused_inputs = de_reg_write_i;

  // Hazard event detection.
  always_comb begin
    mem_busy = (em_mem_read_i | em_mem_write_i) & ~dmem_ready_i;
    load_use = de_mem_read_i && (de_rd_i != REG_X0) &&
               ((d_use_rs1_i && (d_rs1_i == de_rd_i)) ||
                (d_use_rs2_i && (d_rs2_i == de_rd_i)));
  end

  // Next state and zero-latency pipeline controls; priority mem_busy > branch > load-use.
  always_comb begin
    state_nxt     = RUN;
    pc_write_o    = 1'b1;
    fd_write_o    = 1'b1;
    fd_flush_o    = 1'b0;
    de_flush_o    = 1'b0;
    pipe_freeze_o = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    if (reset_i) begin
      state_nxt = RUN;
    end else if (mem_busy) begin
      pipe_freeze_o = 1'b1;
      pc_write_o    = 1'b0;
      fd_write_o    = 1'b0;
      stall_inc     = 1'b1;
      state_nxt     = MEM_WAIT;
    end else if (e_pc_select_i) begin
      fd_flush_o = 1'b1;
      de_flush_o = 1'b1;
      flush_inc  = 1'b1;
    end else if (load_use && (state != LOAD_STALL)) begin
      pc_write_o = 1'b0;
      fd_write_o = 1'b0;
      de_flush_o = 1'b1;
      stall_inc  = 1'b1;
      state_nxt  = LOAD_STALL;
    end
  end

  forward_sel u_fwd_a (
    .rs           (de_rs1_i),
    .em_rd        (em_write_addr_reg_i),
    .em_reg_write (em_reg_write_i),
    .em_mem_read  (em_mem_read_i),
    .mw_rd        (mw_write_addr_reg_i),
    .mw_reg_write (mw_reg_write_i),
    .sel          (fwd_a)
  );

  forward_sel u_fwd_b (
    .rs           (de_rs2_i),
    .em_rd        (em_write_addr_reg_i),
    .em_reg_write (em_reg_write_i),
    .em_mem_read  (em_mem_read_i),
    .mw_rd        (mw_write_addr_reg_i),
    .mw_reg_write (mw_reg_write_i),
    .sel          (fwd_b)
  );

  // Forwarding selects read as register file while reset is held.
  assign fwd_a_o = reset_i ? FWD_REG : fwd_a;
  assign fwd_b_o = reset_i ? FWD_REG : fwd_b;

  // State, wait counter, sticky timeout and performance counters.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= RUN;
      wait_cnt      <= '0;
      mem_timeout_o <= 1'b0;
      stall_cnt_o   <= '0;
      flush_cnt_o   <= '0;
    end else begin
      state <= state_nxt;
      if ((state == MEM_WAIT) && mem_busy) begin
        if (wait_cnt != WAIT_MAX) begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        if ((wait_cnt + WAIT_W'(1)) == WAIT_MAX) begin
          mem_timeout_o <= 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
      if (stall_inc) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (flush_inc) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;
  import pipeline_pkg::*;

  logic        clk_i;
  logic        reset_i;
  logic [4:0]  d_rs1_i, d_rs2_i;
  logic        d_use_rs1_i, d_use_rs2_i;
  logic [4:0]  de_rs1_i, de_rs2_i, de_rd_i;
  logic        de_reg_write_i, de_mem_read_i;
  logic        e_pc_select_i;
  logic [4:0]  em_write_addr_reg_i;
  logic        em_reg_write_i, em_mem_read_i, em_mem_write_i;
  logic        dmem_ready_i;
  logic [4:0]  mw_write_addr_reg_i;
  logic        mw_reg_write_i;
  logic        pc_write_o, fd_write_o, fd_flush_o, de_flush_o, pipe_freeze_o;
  logic [1:0]  fwd_a_o, fwd_b_o;
  logic        mem_timeout_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .d_rs1_i             (d_rs1_i),
    .d_rs2_i             (d_rs2_i),
    .d_use_rs1_i         (d_use_rs1_i),
    .d_use_rs2_i         (d_use_rs2_i),
    .de_rs1_i            (de_rs1_i),
    .de_rs2_i            (de_rs2_i),
    .de_rd_i             (de_rd_i),
    .de_reg_write_i      (de_reg_write_i),
    .de_mem_read_i       (de_mem_read_i),
    .e_pc_select_i       (e_pc_select_i),
    .em_write_addr_reg_i (em_write_addr_reg_i),
    .em_reg_write_i      (em_reg_write_i),
    .em_mem_read_i       (em_mem_read_i),
    .em_mem_write_i      (em_mem_write_i),
    .dmem_ready_i        (dmem_ready_i),
    .mw_write_addr_reg_i (mw_write_addr_reg_i),
    .mw_reg_write_i      (mw_reg_write_i),
    .pc_write_o          (pc_write_o),
    .fd_write_o          (fd_write_o),
    .fd_flush_o          (fd_flush_o),
    .de_flush_o          (de_flush_o),
    .pipe_freeze_o       (pipe_freeze_o),
    .fwd_a_o             (fwd_a_o),
    .fwd_b_o             (fwd_b_o),
    .mem_timeout_o       (mem_timeout_o),
    .stall_cnt_o         (stall_cnt_o),
    .flush_cnt_o         (flush_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    d_rs1_i = 5'd0; d_rs2_i = 5'd0; d_use_rs1_i = 1'b0; d_use_rs2_i = 1'b0;
    de_rs1_i = 5'd0; de_rs2_i = 5'd0; de_rd_i = 5'd0;
    de_reg_write_i = 1'b0; de_mem_read_i = 1'b0; e_pc_select_i = 1'b0;
    em_write_addr_reg_i = 5'd0; em_reg_write_i = 1'b0;
    em_mem_read_i = 1'b0; em_mem_write_i = 1'b0; dmem_ready_i = 1'b0;
    mw_write_addr_reg_i = 5'd0; mw_reg_write_i = 1'b0;
  endtask

  // pc_write, fd_write, fd_flush, de_flush, freeze packed as one 5-bit word
  function automatic logic [31:0] ctl();
    return {27'd0, pc_write_o, fd_write_o, fd_flush_o, de_flush_o, pipe_freeze_o};
  endfunction

  // advance past one rising edge to the following falling edge
  task automatic cyc();
    @(negedge clk_i);
  endtask

  initial begin
    idle();
    reset_i = 1'b1;
    cyc();
    cyc();
    #1;
    chk("reset_ctl", ctl(), 32'b11000);
    chk("reset_fwd", {28'd0, fwd_a_o, fwd_b_o}, 32'd0);
    chk("reset_cnt", stall_cnt_o | flush_cnt_o, 32'd0);
    chk("reset_timeout", {31'd0, mem_timeout_o}, 32'd0);
    cyc();
    reset_i = 1'b0;

    // load-use: lw x5 in execute, add x6,x5,x1 in decode
    de_mem_read_i = 1'b1; de_reg_write_i = 1'b1; de_rd_i = 5'd5;
    d_rs1_i = 5'd5; d_use_rs1_i = 1'b1; d_rs2_i = 5'd1; d_use_rs2_i = 1'b1;
    #1;
    chk("lu_ctl", ctl(), 32'b00010);
    cyc();
    chk("lu_stall_cnt", stall_cnt_o, 32'd1);
    // LOAD_STALL: normal outputs even with the same decode/execute addresses
    em_mem_read_i = 1'b1; em_reg_write_i = 1'b1; em_write_addr_reg_i = 5'd5; dmem_ready_i = 1'b1;
    #1;
    chk("ls_ctl", ctl(), 32'b11000);
    cyc();
    chk("ls_stall_cnt", stall_cnt_o, 32'd1);
    // add now in execute, lw in writeback
    idle();
    de_rs1_i = 5'd5; de_rs2_i = 5'd1; mw_write_addr_reg_i = 5'd5; mw_reg_write_i = 1'b1;
    #1;
    chk("lu_fwd_a", {30'd0, fwd_a_o}, 32'b01);
    chk("lu_fwd_b", {30'd0, fwd_b_o}, 32'b00);
    chk("lu_run_ctl", ctl(), 32'b11000);
    cyc();

    // back-to-back ALU ops: add x3 in memory, execute reads x3 as rs2
    idle();
    em_write_addr_reg_i = 5'd3; em_reg_write_i = 1'b1; de_rs2_i = 5'd3; de_rs1_i = 5'd7;
    mw_write_addr_reg_i = 5'd3; mw_reg_write_i = 1'b1;
    #1;
    chk("alu_fwd_b", {30'd0, fwd_b_o}, 32'b10);
    chk("alu_fwd_a", {30'd0, fwd_a_o}, 32'b00);
    em_write_addr_reg_i = 5'd0; de_rs2_i = 5'd0; mw_write_addr_reg_i = 5'd0;
    #1;
    chk("x0_fwd_b", {30'd0, fwd_b_o}, 32'b00);
    // load in memory stage is not forwarded from there; writeback copy is
    em_write_addr_reg_i = 5'd3; em_mem_read_i = 1'b1; dmem_ready_i = 1'b1;
    de_rs2_i = 5'd3; mw_write_addr_reg_i = 5'd3;
    #1;
    chk("ld_fwd_b", {30'd0, fwd_b_o}, 32'b01);
    cyc();

    // branch plus load-use in the same cycle
    idle();
    e_pc_select_i = 1'b1;
    de_mem_read_i = 1'b1; de_rd_i = 5'd8; d_rs2_i = 5'd8; d_use_rs2_i = 1'b1;
    #1;
    chk("br_ctl", ctl(), 32'b11110);
    cyc();
    chk("br_flush_cnt", flush_cnt_o, 32'd1);
    chk("br_stall_cnt", stall_cnt_o, 32'd1);

    // memory wait of 3 cycles with a branch pending across the freeze
    idle();
    em_mem_read_i = 1'b1; e_pc_select_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_freeze_%0d", i), ctl(), 32'b00001);
      cyc();
    end
    chk("mw_stall_cnt", stall_cnt_o, 32'd4);
    dmem_ready_i = 1'b1;
    #1;
    chk("mw_release_ctl", ctl(), 32'b11110);
    cyc();
    chk("mw_flush_cnt", flush_cnt_o, 32'd2);
    chk("mw_stall_hold", stall_cnt_o, 32'd4);
    idle();
    #1;
    chk("mw_run_ctl", ctl(), 32'b11000);
    cyc();

    // timeout: 20 busy cycles (one entry cycle in RUN, then 19 in MEM_WAIT)
    idle();
    em_mem_write_i = 1'b1;
    cyc();
    for (int i = 1; i <= 19; i++) begin
      cyc();
      if (i == 15) chk("to_before", {31'd0, mem_timeout_o}, 32'd0);
      if (i == 16) chk("to_set", {31'd0, mem_timeout_o}, 32'd1);
    end
    chk("to_stall_cnt", stall_cnt_o, 32'd24);
    dmem_ready_i = 1'b1;
    #1;
    chk("to_release_ctl", ctl(), 32'b11000);
    cyc();
    idle();
    cyc();
    chk("to_sticky", {31'd0, mem_timeout_o}, 32'd1);

    // reset asserted mid-MEM_WAIT with busy inputs still present
    em_mem_read_i = 1'b1; em_write_addr_reg_i = 5'd9; em_reg_write_i = 1'b1;
    de_rs1_i = 5'd4; mw_write_addr_reg_i = 5'd4; mw_reg_write_i = 1'b1;
    cyc();
    cyc();
    chk("pre_rst_stall_cnt", stall_cnt_o, 32'd26);
    #2;
    reset_i = 1'b1;
    #1;
    chk("rst_state", 32'(dut.state), 32'(RUN));
    chk("rst_ctl", ctl(), 32'b11000);
    chk("rst_fwd", {28'd0, fwd_a_o, fwd_b_o}, 32'd0);
    chk("rst_stall_cnt", stall_cnt_o, 32'd0);
    chk("rst_flush_cnt", flush_cnt_o, 32'd0);
    chk("rst_timeout", {31'd0, mem_timeout_o}, 32'd0);
    cyc();
    idle();
    reset_i = 1'b0;
    cyc();
    #1;
    chk("post_rst_ctl", ctl(), 32'b11000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline. Watches register addresses and control bits in decode, execute, memory and writeback, and produces:
- PC and pipeline-register enables (stall)
- bubble/flush controls (load-use, taken branch/jump)
- operand forwarding selects for the execute ALU
- a freeze while a multi-cycle data-memory access is outstanding

Sits beside the `cpu` top level; drives the write-enable and flush inputs of the fetch/decode and decode/execute pipeline registers.

## Interface
- `MEM_TIMEOUT`, 16: max cycles in MEM_WAIT before `mem_timeout_o` sets.
- `CNT_W`, 32: width of the performance counters.

- `clk_i` input 1: clock.
- `reset_i` input 1: reset. One clock; reset is asynchronous and active-high.
- `d_rs1_i`, `d_rs2_i` input 5: source registers of the instruction in decode.
- `d_use_rs1_i`, `d_use_rs2_i` input 1: decode instruction actually reads rs1/rs2.
- `de_rs1_i`, `de_rs2_i` input 5: source registers of the instruction in execute.
- `de_rd_i` input 5: destination register in execute.
- `de_reg_write_i`, `de_mem_read_i` input 1: execute-stage control bits.
- `e_pc_select_i` input 1: branch/jump taken, resolved in execute.
- `em_write_addr_reg_i` input 5: destination register in memory.
- `em_reg_write_i`, `em_mem_read_i`, `em_mem_write_i` input 1: memory-stage control bits.
- `dmem_ready_i` input 1: data memory completes the current access this cycle.
- `mw_write_addr_reg_i` input 5: destination register in writeback.
- `mw_reg_write_i` input 1: writeback-stage control bit.
- `pc_write_o` output 1: 1 = PC advances or loads; 0 = hold.
- `fd_write_o` output 1: fetch/decode register enable.
- `fd_flush_o` output 1: fetch/decode register loads a NOP.
- `de_flush_o` output 1: decode/execute register loads a bubble (all control bits 0).
- `pipe_freeze_o` output 1: hold execute/memory and memory/writeback registers.
- `fwd_a_o`, `fwd_b_o` output 2: ALU operand source. 00 = register file, 01 = writeback result, 10 = memory-stage ALU result.
- `mem_timeout_o` output 1: sticky error flag.
- `stall_cnt_o`, `flush_cnt_o` output `CNT_W`: performance counters.

## Operation
- **States:** RUN, LOAD_STALL, MEM_WAIT.
- **Reset values:**
  - State RUN; counters 0; `mem_timeout_o` 0.
  - `pc_write_o` = `fd_write_o` = 1; all flush/freeze outputs 0; `fwd_*` = 00.
- **Event conditions:**
  - mem_busy = `(em_mem_read_i | em_mem_write_i) & ~dmem_ready_i`.
  - load_use = `de_mem_read_i & de_rd_i != 0 & ((d_use_rs1_i & d_rs1_i == de_rd_i) | (d_use_rs2_i & d_rs2_i == de_rd_i))`.
- **Priority per cycle:** mem_busy > `e_pc_select_i` > load_use.
- **mem_busy** (from any state):
  - `pipe_freeze_o` = 1, `pc_write_o` = 0, `fd_write_o` = 0; no flush is asserted.
  - Next state MEM_WAIT.
  - A branch or load-use seen during the freeze is re-evaluated once the freeze ends.
- **MEM_WAIT:**
  - Outputs stay frozen while mem_busy holds.
  - Wait counter increments every cycle in this state.
  - When it reaches `MEM_TIMEOUT`, `mem_timeout_o` sets; it stays set until reset.
  - When `dmem_ready_i` = 1: outputs release that cycle, wait counter clears, state goes to RUN.
- **Taken branch/jump** (`e_pc_select_i` = 1, no mem_busy):
  - `fd_flush_o` = 1 and `de_flush_o` = 1; `pc_write_o` = 1 so the PC loads the target.
  - `flush_cnt_o` += 1.
  - A concurrent load_use is discarded, because its consumer is flushed.
- **Load-use** (in RUN, no branch, no mem_busy):
  - `pc_write_o` = 0, `fd_write_o` = 0, `de_flush_o` = 1 (one bubble).
  - `stall_cnt_o` += 1; next state LOAD_STALL.
- **LOAD_STALL:** normal outputs, next state RUN. A new load-use cannot match here, because execute holds the bubble.
- **Forwarding**, applied per operand against `de_rs1_i` / `de_rs2_i`:
  - 10 if `em_reg_write_i & ~em_mem_read_i & em_write_addr_reg_i != 0` and the addresses match.
  - Otherwise 01 if `mw_reg_write_i & mw_write_addr_reg_i != 0` and the addresses match.
  - Otherwise 00. Register x0 is never forwarded.
- **Counters:** wrap modulo 2^`CNT_W`; `stall_cnt_o` also counts each MEM_WAIT cycle.

## Timing
- Enable, flush, freeze and `fwd_*` outputs are combinational from the current state and inputs, with zero latency: they take effect at the same clock edge as the pipeline registers.
- State, wait counter, performance counters and `mem_timeout_o` are registered and update on the rising edge.
- A load-use costs exactly 1 bubble; a taken branch costs 2 squashed instructions.
- Reset asserted mid-MEM_WAIT or mid-LOAD_STALL returns to RUN asynchronously, with reset output values, in the same cycle.

## Structure
- Shared package `pipeline_pkg`:
  - state enum;
  - forwarding-select constants `FWD_REG`, `FWD_WB`, `FWD_MEM`;
  - `REG_X0` = 5'd0.
- One sub-module, `forward_sel`: purely combinational, instantiated twice (operand A and operand B).

## Test plan
- **Load-use:** `lw x5` in execute, `add x6,x5,x1` in decode. Required: one cycle with `pc_write_o` = 0 and `de_flush_o` = 1; next cycle `fwd_a_o` = 01; `stall_cnt_o` = 1.
- **Back-to-back ALU ops:** `add x3` in memory, execute reads x3 as rs2. Required: `fwd_b_o` = 10. With `em_write_addr_reg_i` = 0 and `de_rs2_i` = 0, `fwd_b_o` = 00.
- **Branch plus load-use same cycle:** Required: `fd_flush_o` = `de_flush_o` = 1, `pc_write_o` = 1, `flush_cnt_o` = 1, `stall_cnt_o` unchanged.
- **Memory wait:** `em_mem_read_i` = 1 with `dmem_ready_i` low for 3 cycles. Required: 3 frozen cycles, release on the ready cycle, `stall_cnt_o` = 3.
- **Timeout:** `dmem_ready_i` held low for 20 cycles with `MEM_TIMEOUT` = 16. Required: `mem_timeout_o` rises after 16 MEM_WAIT cycles and stays set after ready.
- **Reset during MEM_WAIT:** Required: state RUN immediately, all outputs at reset values, counters 0.
